// File: rtl/mult_div_unit_if.sv
//------------------------------------------------------------------------------
// mult_div_unit_if : operand/command and HI/LO result bundle for mult_div_unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  write_hi;
  logic                  write_lo;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, write_hi, write_lo, write_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, write_hi, write_lo, write_data,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// mult_div_unit : iterative 1-bit/cycle HI/LO multiply/divide unit (MULT/DIV)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mult_div_unit_if.slave    bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [W-1:0]     a_mag, b_mag;
  logic             neg_res, neg_rem;
  logic [2*W:0]     acc;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  // Operand conditioning for the start edge
  logic         signed_in, a_neg_in, b_neg_in;
  logic [W-1:0] a_mag_in, b_mag_in;
  always_comb begin
    signed_in = ~bus.op[0];
    a_neg_in  = signed_in & bus.operand_a[W-1];
    b_neg_in  = signed_in & bus.operand_b[W-1];
    a_mag_in  = a_neg_in ? -bus.operand_a : bus.operand_a;
    b_mag_in  = b_neg_in ? -bus.operand_b : bus.operand_b;
  end

  // acc holds {upper accumulator/remainder (W+1), multiplier/quotient (W)}
  logic         is_div;
  logic [W:0]   mul_sum, div_shift, div_trial;
  logic [2*W:0] mul_next, div_next;
  always_comb begin
    is_div    = op_q[1];
    mul_sum   = acc[2*W:W] + (acc[0] ? {1'b0, a_mag} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:0]} >> 1;
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_trial = div_shift - {1'b0, b_mag};
    if (!div_trial[W])
      div_next = {div_trial, acc[W-2:0], 1'b1};
    else
      div_next = {div_shift, acc[W-2:0], 1'b0};
  end

  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, a_raw;
  logic           div_zero;
  always_comb begin
    prod     = acc[2*W-1:0];
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    a_raw    = neg_rem ? -a_mag : a_mag;
    div_zero = (b_mag == {W{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count == CNT_W'(W - 1)) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 2'b00;
      a_mag   <= '0;
      b_mag   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      count   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.write_hi) hi_q <= bus.write_data;
          if (bus.write_lo) lo_q <= bus.write_data;
          if (bus.start) begin
            op_q    <= bus.op;
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            neg_res <= a_neg_in ^ b_neg_in;
            neg_rem <= a_neg_in;
            acc     <= {{(W+1){1'b0}}, bus.op[1] ? a_mag_in : b_mag_in};
            count   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIXUP: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (!is_div) begin
            hi_q <= prod_fix[2*W-1:W];
            lo_q <= prod_fix[W-1:0];
          end else if (div_zero) begin
            // Divide by zero reports the dividend untouched and all-ones quotient
            hi_q  <= a_raw;
            lo_q  <= {W{1'b1}};
            dbz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
//------------------------------------------------------------------------------
// tb_mult_div_unit : directed table-driven checks for mult_div_unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_unit;
  localparam int DW = 32;
  localparam int NV = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.DATA_WIDTH(DW)) bus ();

  mult_div_unit #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          dbz;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launches one operation, waits for Done and returns edges counted from E0
  task automatic do_op(input logic [1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, output int edges);
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 1;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("dbz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
    while (!bus.done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency_edges", 64'(edges), 64'd34);
    chk("busy_low_in_done_cycle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int edges;
    int seen;
    logic [DW-1:0] lo_before;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    bus.start      = 1'b1;
    bus.op         = 2'b00;
    bus.operand_a  = 32'h5;
    bus.operand_b  = 32'h3;
    bus.write_hi   = 1'b0;
    bus.write_lo   = 1'b0;
    bus.write_data = '0;

    // Reset held for two edges with Start asserted
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, edges);
      chk($sformatf("vec%0d_done", i), 64'(bus.done), 64'd1);
      chk($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse_ends", i), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d_dbz_held", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
    end

    // Idle MTLO
    bus.write_lo   = 1'b1;
    bus.write_data = 32'h00001234;
    @(posedge clk); #1;
    bus.write_lo = 1'b0;
    chk("mtlo_idle", 64'(bus.lo), 64'h1234);
    lo_before = bus.lo;

    // MTHI at the same edge as an accepted Start, then Start+MTHI mid-operation
    bus.op         = 2'b01;
    bus.operand_a  = 32'd2;
    bus.operand_b  = 32'd3;
    bus.start      = 1'b1;
    bus.write_hi   = 1'b1;
    bus.write_data = 32'h00000055;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.write_hi = 1'b0;
    chk("mthi_with_start", 64'(bus.hi), 64'h55);
    repeat (4) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.write_hi   = 1'b1;
    bus.operand_a  = 32'd9;
    bus.operand_b  = 32'd9;
    bus.write_data = 32'hDEAD0000;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.write_hi = 1'b0;
    chk("mthi_ignored_busy", 64'(bus.hi), 64'h55);
    chk("lo_held_during_op", 64'(bus.lo), 64'(lo_before));
    edges = 6;
    while (!bus.done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("busy_op_latency", 64'(edges), 64'd34);
    chk("busy_op_hi", 64'(bus.hi), 64'd0);
    chk("busy_op_lo", 64'(bus.lo), 64'd6);
    @(posedge clk); #1;
    chk("start_not_queued", 64'(bus.busy), 64'd0);

    // Simultaneous idle MTHI/MTLO, then abort by reset at E10
    bus.write_hi   = 1'b1;
    bus.write_lo   = 1'b1;
    bus.write_data = 32'hABCD0000;
    @(posedge clk); #1;
    bus.write_hi = 1'b0;
    bus.write_lo = 1'b0;
    chk("mthi_both", 64'(bus.hi), 64'hABCD0000);
    chk("mtlo_both", 64'(bus.lo), 64'hABCD0000);
    bus.op        = 2'b01;
    bus.operand_a = 32'hFFFFFFFF;
    bus.operand_b = 32'hFFFFFFFF;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the register file. Operands come from ReadDataOne (rs) and ReadDataTwo (rt), and Hi/Lo feed the MFHI/MFLO writeback path. It computes one bit per cycle and uses a Busy/Done handshake that the control unit uses to stall.

Parameters:
DATA_WIDTH, 32, operand width; Hi/Lo are each DATA_WIDTH bits and the iteration count equals DATA_WIDTH.

Ports:
Clock  in  1  system clock; all state changes on its rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  request an operation; sampled only when Busy=0.
Op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
OperandA  in  DATA_WIDTH  rs value (multiplicand / dividend).
OperandB  in  DATA_WIDTH  rt value (multiplier / divisor).
WriteHi  in  1  MTHI: load WriteData into Hi.
WriteLo  in  1  MTLO: load WriteData into Lo.
WriteData  in  DATA_WIDTH  rs value for MTHI/MTLO.
Busy  out  1  operation in progress.
Done  out  1  one-cycle pulse when Hi/Lo have just been updated by an operation.
Hi  out  DATA_WIDTH  HI register.
Lo  out  DATA_WIDTH  LO register.
DivByZero  out  1  last divide had OperandB=0.

Behaviour:
- Reset (sampled high at an edge) has priority over all inputs. It forces state IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0 and iteration counter=0.
- Reset mid-operation aborts the operation: no Done pulse, Hi/Lo are zeroed.
- States:
  - IDLE: Busy=0. At an edge with Start=1, the unit:
    - latches Op and the operand magnitudes (absolute value for signed ops; raw value for unsigned ops);
    - latches the result-sign flags;
    - clears the working accumulator and counter;
    - clears DivByZero;
    - goes to RUN.
  - RUN: Busy=1. Each edge performs one iteration: shift-add for multiply, restoring shift-subtract for divide. The counter increments. After the DATA_WIDTH-th RUN edge, go to FIXUP.
  - FIXUP: Busy=1. At this edge the unit:
    - applies sign correction;
    - writes Hi/Lo;
    - sets Done=1 and DivByZero as applicable;
    - goes to IDLE.
- Done is high for exactly the cycle after the FIXUP edge and is otherwise 0.
- Latency: Start sampled at edge E0; RUN edges E1..E32; FIXUP edge E33. Busy is high after E0 through E33. Done and the new Hi/Lo are visible after E33. A new Start is accepted at E34, i.e. during the Done cycle.
- Hi/Lo hold their previous values for the whole operation; intermediate results live only in internal registers.
- Start while Busy=1 is ignored: not queued, no effect.
- Multiply results: MULT gives the signed 64-bit product; MULTU gives the unsigned product. Hi = upper word, Lo = lower word.
- Divide results:
  - Lo = quotient truncated toward zero; Hi = remainder, carrying the sign of the dividend (DIV) or unsigned (DIVU).
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. No exception.
  - Divide by zero (DIV or DIVU) still takes the full latency. Result is Lo=0xFFFFFFFF, Hi=OperandA (unmodified latched value). DivByZero=1 from the FIXUP edge until the next accepted Start or Reset.
- MTHI/MTLO:
  - When Busy=0, WriteHi/WriteLo load WriteData at the edge; both may be asserted together.
  - While Busy=1 they are ignored.
  - If asserted at the same edge as an accepted Start, the write occurs, and the operation result later overwrites it.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: assert Reset for 2 cycles with Start=1 -> Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, Start at E0 -> Busy high E0..E33; Done pulse after E33; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT 0xFFFFFFFD (-3) * 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; then DIVU 7 / 2 -> Lo=3, Hi=1.
- DIVU 5 / 0 -> Lo=0xFFFFFFFF, Hi=5, DivByZero=1 until next Start; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivByZero=0.
- Idle WriteLo=1, WriteData=0x1234 -> Lo=0x1234. During a MULTU 2*3:
  - Start and WriteHi pulsed at E5 -> both ignored;
  - result Hi=0, Lo=6.
- Abort: Reset at E10 of the next operation -> IDLE, Hi=Lo=0, no Done.
